// File: rtl/vga_pkg.sv
// Shared timing defaults, axis phase encodings and total-size helpers for the VGA timing path.
package vga_pkg;

  localparam int unsigned COUNT_W = 12;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam logic        DEF_H_SYNC_POL = 1'b0;
  localparam logic        DEF_V_SYNC_POL = 1'b0;
  localparam int unsigned DEF_SYNC_DELAY = 1;

  typedef enum logic [1:0] {
    H_PH_ACTIVE = 2'd0,
    H_PH_FRONT  = 2'd1,
    H_PH_SYNC   = 2'd2,
    H_PH_BACK   = 2'd3
  } h_phase_t;

  typedef enum logic [1:0] {
    V_PH_ACTIVE = 2'd0,
    V_PH_FRONT  = 2'd1,
    V_PH_SYNC   = 2'd2,
    V_PH_BACK   = 2'd3
  } v_phase_t;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM and registered sync.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned FRONT    = DEF_H_FRONT,
  parameter int unsigned SYNC     = DEF_H_SYNC,
  parameter int unsigned BACK     = DEF_H_BACK,
  parameter logic        SYNC_POL = DEF_H_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COUNT_W-1:0] count,
  output logic [1:0]         phase,
  output logic               sync,
  output logic               wrap,
  output logic               active_next_c
);

  localparam int unsigned TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [COUNT_W-1:0] LAST       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACTIVE_END = COUNT_W'(VISIBLE - 1);
  localparam logic [COUNT_W-1:0] FRONT_END  = COUNT_W'(VISIBLE + FRONT - 1);
  localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(VISIBLE + FRONT + SYNC - 1);

  localparam logic [1:0] ST_ACTIVE = 2'd0;
  localparam logic [1:0] ST_FRONT  = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;
  localparam logic [1:0] ST_BACK   = 2'd3;

  logic [COUNT_W-1:0] count_q, count_d;
  logic [1:0]         phase_q, phase_d;
  logic               sync_q, sync_d;

  assign wrap = advance && (count_q == LAST);

  // Phase moves on the advance that leaves the last count of the current phase.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    sync_d  = sync_q;
    if (advance) begin
      count_d = wrap ? '0 : count_q + COUNT_W'(1);
      case (phase_q)
        ST_ACTIVE: if (count_q == ACTIVE_END) phase_d = ST_FRONT;
        ST_FRONT:  if (count_q == FRONT_END)  phase_d = ST_SYNC;
        ST_SYNC:   if (count_q == SYNC_END)   phase_d = ST_BACK;
        default:   if (wrap)                  phase_d = ST_ACTIVE;
      endcase
      sync_d = (phase_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign active_next_c = (phase_d == ST_ACTIVE);

  // Reset parks the axis on its last blanking position so the first advance wraps to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= LAST;
      phase_q <= ST_BACK;
      sync_q  <= ~SYNC_POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign phase = phase_q;
  assign sync  = sync_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA pixel timing: row/column, display enable, sync pins and line/frame strobes.
// Define VGA_SYNC_ALIGN_EN to delay hsync/vsync by SYNC_DELAY enabled pixels.
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter logic        H_SYNC_POL = DEF_H_SYNC_POL,
  parameter logic        V_SYNC_POL = DEF_V_SYNC_POL,
  parameter int unsigned SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               pixel_enable,
  output logic [COUNT_W-1:0] column,
  output logic [COUNT_W-1:0] row,
  output logic               display_enable,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  if (SYNC_DELAY < 1 || SYNC_DELAY > 7) begin : g_bad_sync_delay
    $error("SYNC_DELAY must be in 1..7");
  end

  logic [1:0] h_phase_raw, v_phase_raw;
  logic       h_sync, v_sync, h_wrap, v_wrap, h_active_next, v_active_next;
  h_phase_t   h_phase;
  v_phase_t   v_phase;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .SYNC_POL(H_SYNC_POL)
  ) u_h_axis (
    .clk(vga_clock), .rst_n(reset), .advance(pixel_enable),
    .count(column), .phase(h_phase_raw), .sync(h_sync), .wrap(h_wrap),
    .active_next_c(h_active_next)
  );

  // Vertical axis steps once per completed line.
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .SYNC_POL(V_SYNC_POL)
  ) u_v_axis (
    .clk(vga_clock), .rst_n(reset), .advance(h_wrap),
    .count(row), .phase(v_phase_raw), .sync(v_sync), .wrap(v_wrap),
    .active_next_c(v_active_next)
  );

  assign h_phase = h_phase_t'(h_phase_raw);
  assign v_phase = v_phase_t'(v_phase_raw);

  logic display_enable_q, display_enable_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    display_enable_d = display_enable_q;
    line_start_d     = line_start_q;
    frame_start_d    = frame_start_q;
    if (pixel_enable) begin
      display_enable_d = h_active_next && v_active_next;
      line_start_d     = h_wrap;
      frame_start_d    = h_wrap && v_wrap;
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      display_enable_q <= 1'b0;
      line_start_q     <= 1'b0;
      frame_start_q    <= 1'b0;
    end else begin
      display_enable_q <= display_enable_d;
      line_start_q     <= line_start_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign display_enable = display_enable_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

`ifdef VGA_SYNC_ALIGN_EN
  // Sync shift register: stage 0 takes the position-aligned sync, the last stage drives the pin.
  logic [SYNC_DELAY-1:0] hsync_pipe_q, hsync_pipe_d;
  logic [SYNC_DELAY-1:0] vsync_pipe_q, vsync_pipe_d;

  always_comb begin
    hsync_pipe_d = hsync_pipe_q;
    vsync_pipe_d = vsync_pipe_q;
    if (pixel_enable) begin
      hsync_pipe_d = SYNC_DELAY'({hsync_pipe_q, h_sync});
      vsync_pipe_d = SYNC_DELAY'({vsync_pipe_q, v_sync});
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      hsync_pipe_q <= {SYNC_DELAY{~H_SYNC_POL}};
      vsync_pipe_q <= {SYNC_DELAY{~V_SYNC_POL}};
    end else begin
      hsync_pipe_q <= hsync_pipe_d;
      vsync_pipe_q <= vsync_pipe_d;
    end
  end

  assign hsync = hsync_pipe_q[SYNC_DELAY-1];
  assign vsync = vsync_pipe_q[SYNC_DELAY-1];
`else
  assign hsync = h_sync;
  assign vsync = v_sync;
`endif

  de_matches_phase_a: assert property (@(posedge vga_clock) disable iff (!reset)
    display_enable == ((h_phase == H_PH_ACTIVE) && (v_phase == V_PH_ACTIVE)));

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default-timing instance plus a shrunken-geometry instance for whole frames.
`timescale 1ns/1ps
module tb_vga_timing_generator;
  import vga_pkg::*;

  localparam int unsigned SD = 1;
  localparam int B_HV = 16, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VV = 10, B_VF = 1, B_VS = 2, B_VB = 2;

  typedef struct packed {
    logic [COUNT_W-1:0] col;
    logic [COUNT_W-1:0] row;
    logic de, hs, vs, ls, fs;
  } obs_t;

  logic vga_clock = 1'b0;
  logic reset = 1'b0;
  logic pixel_enable = 1'b0;

  logic [COUNT_W-1:0] col_a, row_a, col_b, row_b;
  logic de_a, hs_a, vs_a, ls_a, fs_a;
  logic de_b, hs_b, vs_b, ls_b, fs_b;

  always #5 vga_clock = ~vga_clock;

  vga_timing_generator #(.SYNC_DELAY(SD)) u_dut_a (
    .vga_clock(vga_clock), .reset(reset), .pixel_enable(pixel_enable),
    .column(col_a), .row(row_a), .display_enable(de_a), .hsync(hs_a), .vsync(vs_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_generator #(
    .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
    .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .SYNC_DELAY(SD)
  ) u_dut_b (
    .vga_clock(vga_clock), .reset(reset), .pixel_enable(pixel_enable),
    .column(col_b), .row(row_b), .display_enable(de_b), .hsync(hs_b), .vsync(vs_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int checks = 0;
  int errors = 0;
  obs_t qa[$];
  obs_t qb[$];

  obs_t          m_obs[2];
  logic          m_hraw[2];
  logic          m_vraw[2];
  logic [SD-1:0] m_hdly[2];
  logic [SD-1:0] m_vdly[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected col=%0d row=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               name, got.col, got.row, got.de, got.hs, got.vs, got.ls, got.fs,
               exp.col, exp.row, exp.de, exp.hs, exp.vs, exp.ls, exp.fs);
    end
  endtask

  // Reference: position walks the raster, outputs are closed-form functions of the position.
  task automatic model_step(input int k, input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb,
                            input logic rst, input logic pe);
    int ht, vt, c, r;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (!rst) begin
      m_obs[k].col = COUNT_W'(ht - 1);
      m_obs[k].row = COUNT_W'(vt - 1);
      m_obs[k].de = 1'b0; m_obs[k].hs = 1'b1; m_obs[k].vs = 1'b1;
      m_obs[k].ls = 1'b0; m_obs[k].fs = 1'b0;
      m_hraw[k] = 1'b1; m_vraw[k] = 1'b1;
      m_hdly[k] = '1;   m_vdly[k] = '1;
    end else if (pe) begin
      c = int'(m_obs[k].col);
      r = int'(m_obs[k].row);
      if (c == ht - 1) begin
        c = 0;
        r = (r == vt - 1) ? 0 : r + 1;
      end else begin
        c = c + 1;
      end
`ifdef VGA_SYNC_ALIGN_EN
      for (int i = SD - 1; i > 0; i--) begin
        m_hdly[k][i] = m_hdly[k][i-1];
        m_vdly[k][i] = m_vdly[k][i-1];
      end
      m_hdly[k][0] = m_hraw[k];
      m_vdly[k][0] = m_vraw[k];
`endif
      m_hraw[k] = !((c >= hv + hf) && (c < hv + hf + hs));
      m_vraw[k] = !((r >= vv + vf) && (r < vv + vf + vs));
      m_obs[k].col = COUNT_W'(c);
      m_obs[k].row = COUNT_W'(r);
      m_obs[k].de  = (c < hv) && (r < vv);
      m_obs[k].ls  = (c == 0);
      m_obs[k].fs  = (c == 0) && (r == 0);
`ifdef VGA_SYNC_ALIGN_EN
      m_obs[k].hs = m_hdly[k][SD-1];
      m_obs[k].vs = m_vdly[k][SD-1];
`else
      m_obs[k].hs = m_hraw[k];
      m_obs[k].vs = m_vraw[k];
`endif
    end
  endtask

  // Drive inputs just after a falling edge and queue what the next rising edge must produce.
  task automatic tick(input logic rst, input logic pe);
    @(negedge vga_clock);
    #1;
    reset = rst;
    pixel_enable = pe;
    model_step(0, 640, 16, 96, 48, 480, 10, 2, 33, rst, pe);
    qa.push_back(m_obs[0]);
    model_step(1, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, rst, pe);
    qb.push_back(m_obs[1]);
  endtask

  always @(negedge vga_clock) begin
    obs_t exp_o, got_o;
    if (qa.size() > 0) begin
      exp_o = qa.pop_front();
      got_o = {col_a, row_a, de_a, hs_a, vs_a, ls_a, fs_a};
      chk_obs("scoreboard_a", got_o, exp_o);
    end
    if (qb.size() > 0) begin
      exp_o = qb.pop_front();
      got_o = {col_b, row_b, de_b, hs_b, vs_b, ls_b, fs_b};
      chk_obs("scoreboard_b", got_o, exp_o);
    end
  end

  initial begin
    int de_cnt, hlow_cnt, hlow_first, hlow_last, ls_cnt, ls_p0, ls_p1;
    int fsb_cnt, fsb_p0, fsb_p1, deb_cnt, vlow_cnt, vfall_col, bound, hfirst_exp, hlast_exp, vcol_exp;
    de_cnt = 0; hlow_cnt = 0; hlow_first = -1; hlow_last = -1; ls_cnt = 0; ls_p0 = 0; ls_p1 = 0;
    fsb_cnt = 0; fsb_p0 = 0; fsb_p1 = 0; deb_cnt = 0; vlow_cnt = 0; vfall_col = -1;
`ifdef VGA_SYNC_ALIGN_EN
    hfirst_exp = 657; hlast_exp = 752; vcol_exp = 1;
`else
    hfirst_exp = 656; hlast_exp = 751; vcol_exp = 0;
`endif

    repeat (4) tick(1'b0, 1'b1);
    chk("reset_column", int'(col_a), 799);
    chk("reset_row", int'(row_a), 524);
    chk("reset_hsync", int'(hs_a), 1);
    chk("reset_vsync", int'(vs_a), 1);
    chk("reset_display_enable", int'(de_a), 0);

    tick(1'b1, 1'b1);
    for (int i = 0; i <= 1700; i++) begin
      tick(1'b1, 1'b1);
      if (i == 0) begin
        chk("first_column", int'(col_a), 0);
        chk("first_row", int'(row_a), 0);
        chk("first_frame_start", int'(fs_a), 1);
        chk("first_line_start", int'(ls_a), 1);
        chk("first_display_enable", int'(de_a), 1);
      end
      if (i < 800) begin
        if (de_a) de_cnt++;
        if (!hs_a) begin
          hlow_cnt++;
          if (hlow_first < 0) hlow_first = int'(col_a);
          hlow_last = int'(col_a);
        end
      end
      if (ls_a) begin
        ls_cnt++;
        if (ls_cnt == 1) ls_p0 = i;
        if (ls_cnt == 2) ls_p1 = i;
      end
      if (fs_b) begin
        fsb_cnt++;
        if (fsb_cnt == 1) fsb_p0 = i;
        if (fsb_cnt == 2) fsb_p1 = i;
      end
      if (i < 360) begin
        if (de_b) deb_cnt++;
        if (!vs_b) begin
          vlow_cnt++;
          if (vfall_col < 0) vfall_col = int'(col_b);
        end
      end
    end
    chk("line_de_cycles", de_cnt, 640);
    chk("line_hsync_low_cycles", hlow_cnt, 96);
    chk("hsync_first_low_column", hlow_first, hfirst_exp);
    chk("hsync_last_low_column", hlow_last, hlast_exp);
    chk("line_start_count", ls_cnt, 3);
    chk("line_start_interval", ls_p1 - ls_p0, 800);
    chk("small_frame_start_interval", fsb_p1 - fsb_p0, 360);
    chk("small_frame_de_cycles", deb_cnt, 160);
    chk("small_frame_vsync_low_cycles", vlow_cnt, 48);
    chk("small_vsync_fall_column", vfall_col, vcol_exp);

    chk("toggle_start_column", int'(col_a), 100);
    tick(1'b1, 1'b0);
    chk("toggle_column_0", int'(col_a), 101);
    tick(1'b1, 1'b0);
    chk("toggle_column_1", int'(col_a), 101);
    tick(1'b1, 1'b1);
    chk("toggle_column_2", int'(col_a), 101);
    tick(1'b1, 1'b1);
    chk("toggle_column_3", int'(col_a), 102);

    bound = 0;
    while (col_a != COUNT_W'(299) && bound < 1000) begin
      tick(1'b1, 1'b1);
      bound++;
    end
    chk("reach_column_299", int'(col_a), 299);
    chk("reach_row_2", int'(row_a), 2);
    tick(1'b0, 1'b1);
    #1;
    chk("async_reset_column", int'(col_a), 799);
    chk("async_reset_row", int'(row_a), 524);
    chk("async_reset_display_enable", int'(de_a), 0);
    chk("async_reset_hsync", int'(hs_a), 1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("restart_column", int'(col_a), 0);
    chk("restart_row", int'(row_a), 0);
    chk("restart_frame_start", int'(fs_a), 1);
    repeat (3) tick(1'b1, 1'b1);

    for (int w = 0; w < 10 && (qa.size() > 0 || qb.size() > 0); w++) @(negedge vga_clock);
    #1;
    chk("scoreboard_drained", qa.size() + qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
